uart_rx_fifo: RTL

//   Receive buffer directly downstream of the UART receiver. Captures each completed byte
//   (rising edge of the receiver's done flag) into a circular FIFO. Presents bytes to the

---
 rtl/uart_rx_fifo_pkg.sv | 28 ++
 rtl/uart_fifo_ram.sv | 41 ++++
 rtl/uart_rx_fifo.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// ============================================================================
// Module   : uart_rx_fifo_pkg
// Purpose  : Shared constants for the UART receive FIFO. It also supplies
//            default values for the byte-width and depth macros when the UART
//            parameter header has not already defined them.
// Macros   : DATA_WIDTH     (default 8)  - received byte width
//            RX_FIFO_DEPTH  (default 16) - default receive FIFO depth
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

`ifndef RX_FIFO_DEPTH
`define RX_FIFO_DEPTH 16
`endif

package uart_rx_fifo_pkg;

  // Width and saturation ceiling of the optional dropped-byte counter
  localparam int unsigned DROP_CNT_W   = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

endpackage : uart_rx_fifo_pkg

`default_nettype wire

// File: rtl/uart_fifo_ram.sv
// ============================================================================
// Module   : uart_fifo_ram
// Purpose  : DEPTH x DATA_WIDTH simple dual-port storage for the UART FIFOs.
//            Synchronous write and asynchronous read. The storage array has
//            no reset, so it can map onto distributed RAM.
// Ports    : clk_i    - write clock (posedge)
//            we_i     - write enable
//            waddr_i  - write address
//            wdata_i  - write data
//            raddr_i  - read address
//            rdata_o  - read data, combinational from raddr_i
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo_ram #(
  parameter  int unsigned DEPTH      = 16,
  parameter  int unsigned DATA_WIDTH = 8,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : uart_fifo_ram

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Receive buffer behind the UART receiver. Each rising edge of the
//            receiver's done flag captures one byte into a circular FIFO; the
//            head byte is offered show-ahead over valid/ready. A sticky flag
//            records bytes dropped because the FIFO was full.
// Macro    : RX_FIFO_STATS_EN - when defined, adds o_drop_cnt, a saturating
//            count of dropped bytes cleared by i_clr_ovf.
// Ports    : sysclk      - system clock (posedge)
//            rst_n       - synchronous reset, active-low
//            i_rx_d      - receiver byte-done flag (may stay high >1 cycle)
//            i_rx_byte   - received byte, stable while i_rx_d is high
//            o_data      - head-of-FIFO byte, zero when empty
//            o_valid     - FIFO non-empty
//            i_ready     - consumer takes o_data this cycle
//            o_level     - number of entries held, 0..DEPTH
//            o_full      - o_level == DEPTH
//            o_overflow  - sticky: a byte was dropped while full
//            i_clr_ovf   - clears o_overflow (and o_drop_cnt)
//            o_drop_cnt  - dropped-byte count, saturating (stats build only)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH      = `RX_FIFO_DEPTH,
  parameter  int unsigned DATA_WIDTH = `DATA_WIDTH,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  i_rx_d,
  input  logic [DATA_WIDTH-1:0] i_rx_byte,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [AW:0]           o_level,
  output logic                  o_full,
  output logic                  o_overflow,
  input  logic                  i_clr_ovf
`ifdef RX_FIFO_STATS_EN
  ,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
`endif
);

  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           level_q,  level_d;
  logic                  rx_d_q;
  logic                  ovf_q,    ovf_d;
  logic                  push_ev;
  logic                  pop;
  logic                  wr_en;
  logic                  drop;
  logic [DATA_WIDTH-1:0] rd_data;

  // One push per done pulse regardless of its length
  assign push_ev = i_rx_d & ~rx_d_q;
  assign o_valid = (level_q != '0);
  assign o_full  = (level_q == LEVEL_FULL);
  assign pop     = o_valid & i_ready;
  // When full, a simultaneous pop frees the slot the push needs
  assign wr_en   = push_ev & (~o_full | pop);
  assign drop    = push_ev & o_full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    // A new drop outranks a coincident clear
    if (drop) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      // Held high through reset so a flag already high at release is ignored
      rx_d_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rx_d_q   <= i_rx_d;
      ovf_q    <= ovf_d;
    end
  end

  uart_fifo_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk_i   (sysclk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_rx_byte),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Storage is not reset; masking keeps stale contents off the port when empty
  assign o_data     = o_valid ? rd_data : '0;
  assign o_level    = level_q;
  assign o_overflow = ovf_q;

`ifdef RX_FIFO_STATS_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (i_clr_ovf) begin
      drop_cnt_d = drop ? DROP_CNT_W'(1) : '0;
    end else if (drop && (drop_cnt_q != DROP_CNT_MAX)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule : uart_rx_fifo

`default_nettype wire
